mem_arbiter: RTL and testbench

- Single-port memory arbiter and sequencer for the RV32 core's move to one unified instruction/data memory.
- Shares the memory between the fetch path (PC-addressed) and the load/store path (ALU-result-addressed).
- Runs a fixed-latency access sequence and drives `stall`, so the PC register loads only when the fetch completes.
- Data port has priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_arb_prio.sv | 34 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Grant decision between fetch and data ports; data wins until fetch has
// waited through STARVE_MAX consecutive data grants.
module mem_arbiter_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant,
  output logic grant_dm
);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved  = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_dm = dm_req && !starved;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (grant_dm && if_req) begin
        if (starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer sharing one memory between the fetch
// and load/store paths, with a fixed-latency access sequence and stall.
//
//   state    | meaning
//   ST_IDLE  | arbitrate; latch winner's addr/we/wdata and owner
//   ST_ISSUE | mem_en strobe for one cycle, load latency timer
//   ST_WAIT  | count down MEM_LAT cycles, capture read data on last
//   ST_RESP  | one-cycle ack to the owner
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall
);

  state_t           state, state_nxt;
  owner_t           owner;
  logic             lat_we;
  logic [CNT_W-1:0] lat_cnt;
  logic             grant;
  logic             grant_dm;
  logic             last_wait;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^{if_addr[1:0], dm_addr[1:0]};

  assign grant     = (state == ST_IDLE) && (if_req || dm_req);
  assign last_wait = (state == ST_WAIT) && (lat_cnt == CNT_W'(1));
  assign stall     = (if_req && !if_ack) || (dm_req && !dm_ack);

  mem_arbiter_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb_prio (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant   (grant),
    .grant_dm(grant_dm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (last_wait) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The mem_* registers double as the request latch: loaded once at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_IF;
      lat_we    <= 1'b0;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant) begin
        owner     <= grant_dm ? OWN_DM : OWN_IF;
        lat_we    <= grant_dm && dm_we;
        mem_en    <= 1'b1;
        mem_we    <= grant_dm && dm_we;
        mem_addr  <= grant_dm ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
        mem_wdata <= grant_dm ? dm_wdata : '0;
      end
      if (state == ST_ISSUE) lat_cnt <= CNT_W'(MEM_LAT);
      if (state == ST_WAIT)  lat_cnt <= lat_cnt - 1'b1;
      if (last_wait) begin
        if (owner == OWN_IF) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end else begin
          if (!lat_we) dm_rdata <= mem_rdata;
          dm_ack <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: timing model plus directed vectors.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 8;
  localparam int LAT    = 1;
  localparam int SMAX   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [7:0]  if_addr = 0, dm_addr = 0;
  logic [31:0] dm_wdata = 0;
  logic        if_ack, dm_ack, mem_en, mem_we, stall;
  logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;

  logic        l3_if_req = 0, l3_dm_req = 0, l3_dm_we = 0;
  logic [7:0]  l3_if_addr = 0, l3_dm_addr = 0;
  logic [31:0] l3_dm_wdata = 0;
  logic        l3_if_ack, l3_dm_ack, l3_mem_en, l3_mem_we, l3_stall;
  logic [31:0] l3_if_rdata, l3_dm_rdata, l3_mem_wdata, l3_mem_rdata;
  logic [5:0]  l3_mem_addr;

  mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(3), .STARVE_MAX(SMAX)) u3 (
    .clk(clk), .rst(rst),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ack(l3_if_ack), .if_rdata(l3_if_rdata),
    .dm_req(l3_dm_req), .dm_we(l3_dm_we), .dm_addr(l3_dm_addr), .dm_wdata(l3_dm_wdata),
    .dm_ack(l3_dm_ack), .dm_rdata(l3_dm_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata), .stall(l3_stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0050_0093;
    if (i == 8) return 32'h1234_5678;
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Memory with MEM_LAT=1 behind dut; garbage whenever no read is due.
  logic [31:0] mem [64];
  bit          mem_ready = 0;
  logic        rd_v = 0;
  logic [5:0]  rd_a = 0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] = init_word(i);
      mem_ready = 1;
    end
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    rd_v <= mem_en && !mem_we;
    rd_a <= mem_addr;
  end
  assign mem_rdata = rd_v ? mem[rd_a] : 32'hBAD0_0000;

  // Memory with MEM_LAT=3 behind u3: word n reads as 0xA5000000 + n.
  logic [5:0] p0 = 0, p1 = 0, p2 = 0;
  logic       v0 = 0, v1 = 0, v2 = 0;
  always @(posedge clk) begin
    p0 <= l3_mem_addr; v0 <= l3_mem_en;
    p1 <= p0;          v1 <= v0;
    p2 <= p1;          v2 <= v1;
  end
  assign l3_mem_rdata = v2 ? (32'hA500_0000 | 32'(p2)) : 32'hBAD0_0000;

  // Model: t counts cycles since the grant edge; an access occupies LAT+2
  // cycles after the grant, the ack lands on the last, then one idle cycle.
  logic [31:0] gold [64];
  bit          gold_ready = 0;
  int          t = 0, m_starve = 0;
  logic        m_dm = 0, m_we = 0;
  logic [5:0]  m_wa = 0;
  logic        e_if_ack = 0, e_dm_ack = 0, e_en = 0, e_we = 0;
  logic [5:0]  e_addr = 0;
  logic [31:0] e_wdata = 0, e_if_rd = 0, e_dm_rd = 0;

  always @(posedge clk or posedge rst) begin
    if (!gold_ready) begin
      for (int i = 0; i < 64; i++) gold[i] = init_word(i);
      gold_ready = 1;
    end
    if (rst) begin
      t = 0; m_starve = 0;
      e_if_ack = 0; e_dm_ack = 0; e_en = 0; e_we = 0;
      e_addr = 0; e_wdata = 0; e_if_rd = 0; e_dm_rd = 0;
    end else begin
      e_en = 0; e_we = 0; e_if_ack = 0; e_dm_ack = 0;
      if (t == 0) begin
        if (if_req || dm_req) begin
          m_dm = dm_req && !(if_req && m_starve == SMAX);
          m_starve = (m_dm && if_req) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
          m_we = m_dm && dm_we;
          m_wa = m_dm ? dm_addr[7:2] : if_addr[7:2];
          e_en = 1; e_we = m_we; e_addr = m_wa;
          if (m_we) begin
            e_wdata = dm_wdata;
            gold[m_wa] = dm_wdata;
          end
          t = 1;
        end
      end else if (t == LAT + 2) begin
        t = 0;
      end else begin
        t++;
        if (t == LAT + 2) begin
          if (m_dm) begin
            e_dm_ack = 1;
            if (!m_we) e_dm_rd = gold[m_wa];
          end else begin
            e_if_ack = 1;
            e_if_rd = gold[m_wa];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_if_ack", 32'(if_ack), 32'(e_if_ack));
      chk("m_dm_ack", 32'(dm_ack), 32'(e_dm_ack));
      chk("m_mem_en", 32'(mem_en), 32'(e_en));
      if (e_en) begin
        chk("m_mem_we", 32'(mem_we), 32'(e_we));
        chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("m_mem_wdata", mem_wdata, e_wdata);
      end
      chk("m_if_rdata", if_rdata, e_if_rd);
      chk("m_dm_rdata", dm_rdata, e_dm_rd);
      chk("m_stall", 32'(stall), 32'((if_req && !e_if_ack) || (dm_req && !e_dm_ack)));
    end
  end

  task automatic wait_ack(input bit is_dm, input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = is_dm ? dm_ack : if_ack;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  int   g;
  logic grants [6];
  logic exp_seq [6];

  initial begin
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_if_ack", 32'(if_ack), 0);
    chk("rst_dm_ack", 32'(dm_ack), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;

    // Single fetch
    if_req = 1; if_addr = 8'h10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fetch_stall", 32'(stall), (c < 3) ? 1 : 0);
      if (c == 1) begin
        chk("fetch_en", 32'(mem_en), 1);
        chk("fetch_addr", 32'(mem_addr), 32'h04);
        chk("fetch_we", 32'(mem_we), 0);
      end
      if (c == 3) begin
        chk("fetch_ack", 32'(if_ack), 1);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
      end
    end
    @(posedge clk); #1 if_req = 0;
    @(posedge clk); #1;

    // Simultaneous fetch and load: data first
    if_req = 1; if_addr = 8'h14; dm_req = 1; dm_we = 0; dm_addr = 8'h20;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) chk("sim_dm_addr", 32'(mem_addr), 32'h08);
      if (c == 3) begin
        chk("sim_dm_ack", 32'(dm_ack), 1);
        chk("sim_dm_rdata", dm_rdata, 32'h1234_5678);
        @(posedge clk); #1 dm_req = 0;
      end
      if (c == 5) begin
        chk("sim_if_en", 32'(mem_en), 1);
        chk("sim_if_addr", 32'(mem_addr), 32'h05);
      end
      if (c == 7) chk("sim_if_ack", 32'(if_ack), 1);
    end
    @(posedge clk); #1 if_req = 0;
    @(posedge clk); #1;

    // Store, then read it back
    dm_req = 1; dm_we = 1; dm_addr = 8'h0B; dm_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("st_en", 32'(mem_en), 1);
        chk("st_we", 32'(mem_we), 1);
        chk("st_addr", 32'(mem_addr), 32'h02);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      if (c == 3) begin
        chk("st_ack", 32'(dm_ack), 1);
        chk("st_rdata_held", dm_rdata, 32'h1234_5678);
      end
    end
    @(posedge clk); #1 dm_we = 0; dm_addr = 8'h08; dm_wdata = 0;
    wait_ack(1, "ld_after_st_ack");
    chk("ld_after_st_rdata", dm_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1 dm_req = 0;
    @(posedge clk); #1;

    // Starvation: both held; expect 4 DM grants, one IF, then DM again
    if_req = 1; if_addr = 8'h30; dm_req = 1; dm_we = 0; dm_addr = 8'h40;
    for (int i = 0; i < 6; i++) grants[i] = 1'bx;
    g = 0;
    for (int c = 0; c < 80 && g < 6; c++) begin
      @(negedge clk);
      if (mem_en) begin
        grants[g] = (mem_addr == 6'h10);
        if (mem_addr == 6'h0C) chk("starve_cnt_after_if", 32'(dut.u_arb_prio.starve_cnt), 0);
        g++;
      end
    end
    chk("starve_grant_count", 32'(g), 6);
    for (int i = 0; i < 6; i++) chk("starve_grant_owner", 32'(grants[i]), 32'(exp_seq[i]));
    wait_ack(1, "starve_last_dm_ack");
    @(posedge clk); #1 dm_req = 0;
    wait_ack(0, "starve_final_if_ack");
    @(posedge clk); #1 if_req = 0;
    @(posedge clk); #1;

    // Reset during WAIT of a load
    dm_req = 1; dm_we = 0; dm_addr = 8'h04;
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_mem_en", 32'(mem_en), 0);
    chk("midrst_dm_ack", 32'(dm_ack), 0);
    chk("midrst_mem_addr", 32'(mem_addr), 0);
    chk("midrst_dm_rdata", dm_rdata, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    dm_req = 0;
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("postrst_mem_en", 32'(mem_en), 0);
      chk("postrst_dm_ack", 32'(dm_ack), 0);
      chk("postrst_state", 32'(dut.state), 32'(ST_IDLE));
    end

    // MEM_LAT=3 instance: load, then back-to-back second load
    @(posedge clk); #1 l3_dm_req = 1; l3_dm_addr = 8'h08;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) chk("l3_stall_c0", 32'(l3_stall), 1);
      if (c == 1) begin
        chk("l3_en_c1", 32'(l3_mem_en), 1);
        chk("l3_addr_c1", 32'(l3_mem_addr), 32'h02);
        chk("l3_we_c1", 32'(l3_mem_we), 0);
        chk("l3_wdata_c1", l3_mem_wdata, 0);
      end
      if (c >= 2 && c <= 4) chk("l3_en_wait", 32'(l3_mem_en), 0);
      if (c == 4) chk("l3_ack_c4", 32'(l3_dm_ack), 0);
      if (c == 5) begin
        chk("l3_ack_c5", 32'(l3_dm_ack), 1);
        chk("l3_rdata_c5", l3_dm_rdata, 32'hA500_0002);
        chk("l3_stall_c5", 32'(l3_stall), 0);
        chk("l3_if_ack_c5", 32'(l3_if_ack), 0);
        @(posedge clk); #1 l3_dm_addr = 8'h0C;
      end
      if (c == 10) chk("l3_ack_c10", 32'(l3_dm_ack), 0);
      if (c == 11) begin
        chk("l3_ack_c11", 32'(l3_dm_ack), 1);
        chk("l3_rdata_c11", l3_dm_rdata, 32'hA500_0003);
      end
    end
    @(posedge clk); #1 l3_dm_req = 0;
    @(negedge clk);
    chk("l3_if_rdata", l3_if_rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
